// File: rtl/nec_ir_tx.sv
// NEC IR transmitter: one command byte per valid/ready handshake becomes a full frame (lead, 32 bits LSB first, stop).
// Optional NEC_REPEAT_EN: while cmd_hold stays high, repeat codes follow every 192 units after the frame.
module nec_ir_tx #(
  parameter logic [7:0] ADDR      = 8'h00,
  parameter int         UNIT_CYC  = 28125,
  parameter int         CARR_HALF = 658
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_hold,
  output logic       ir_mark,
  output logic       ir_out,
  output logic       busy,
  output logic       done
);

  localparam int CW  = $clog2(UNIT_CYC);
  localparam int CCW = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
`ifdef NEC_REPEAT_EN
    , GAP, RPT_MARK, RPT_SPACE, RPT_STOP
`endif
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cyc;
  logic [4:0]       r_units;
  logic [4:0]       r_bit;
  logic [31:0]      r_shift;
  logic             r_mark;
  logic             r_carr;
  logic [CCW-1:0]   r_carr_cnt;
  logic             r_done;
`ifdef NEC_REPEAT_EN
  logic [7:0]       r_period;
`else
  logic             w_unused_hold;
  assign w_unused_hold = cmd_hold;
`endif

  logic [4:0] w_seg_len;
  logic       w_unit_end;
  logic       w_seg_end;

  always_comb begin
    w_seg_len = 5'd1;
    case (r_state)
      LEAD_MARK:  w_seg_len = 5'd16;
      LEAD_SPACE: w_seg_len = 5'd8;
      BIT_SPACE:  w_seg_len = r_shift[0] ? 5'd3 : 5'd1;
`ifdef NEC_REPEAT_EN
      RPT_MARK:   w_seg_len = 5'd16;
      RPT_SPACE:  w_seg_len = 5'd4;
`endif
      default:    w_seg_len = 5'd1;
    endcase
  end

  assign w_unit_end = (r_cyc == CW'(UNIT_CYC - 1));
  assign w_seg_end  = w_unit_end && (r_units == w_seg_len - 5'd1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_cyc      <= '0;
      r_units    <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_mark     <= 1'b0;
      r_carr     <= 1'b0;
      r_carr_cnt <= '0;
      r_done     <= 1'b0;
`ifdef NEC_REPEAT_EN
      r_period   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_carr_cnt == CCW'(CARR_HALF - 1)) begin
        r_carr_cnt <= '0;
        r_carr     <= ~r_carr;
      end else begin
        r_carr_cnt <= r_carr_cnt + CCW'(1);
      end

      if (r_state != IDLE) begin
        if (w_unit_end) begin
          r_cyc <= '0;
`ifdef NEC_REPEAT_EN
          r_period <= r_period + 8'd1;
          if (r_state != GAP) r_units <= r_units + 5'd1;
`else
          r_units <= r_units + 5'd1;
`endif
        end else begin
          r_cyc <= r_cyc + CW'(1);
        end
      end

      // Later assignments override the free-running defaults above on segment boundaries.
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_shift    <= {~cmd_data, cmd_data, ~ADDR, ADDR};
          r_state    <= LEAD_MARK;
          r_mark     <= 1'b1;
          r_carr     <= 1'b1;
          r_carr_cnt <= '0;
          r_cyc      <= '0;
          r_units    <= '0;
          r_bit      <= '0;
`ifdef NEC_REPEAT_EN
          r_period   <= '0;
`endif
        end
        LEAD_MARK: if (w_seg_end) begin
          r_state <= LEAD_SPACE;
          r_mark  <= 1'b0;
          r_units <= '0;
        end
        LEAD_SPACE: if (w_seg_end) begin
          r_state    <= BIT_MARK;
          r_mark     <= 1'b1;
          r_carr     <= 1'b1;
          r_carr_cnt <= '0;
          r_units    <= '0;
        end
        BIT_MARK: if (w_seg_end) begin
          r_state <= BIT_SPACE;
          r_mark  <= 1'b0;
          r_units <= '0;
        end
        BIT_SPACE: if (w_seg_end) begin
          r_shift    <= {1'b0, r_shift[31:1]};
          r_bit      <= r_bit + 5'd1;
          r_state    <= (r_bit == 5'd31) ? STOP_MARK : BIT_MARK;
          r_mark     <= 1'b1;
          r_carr     <= 1'b1;
          r_carr_cnt <= '0;
          r_units    <= '0;
        end
        STOP_MARK: if (w_seg_end) begin
          r_mark  <= 1'b0;
          r_units <= '0;
`ifdef NEC_REPEAT_EN
          r_state <= GAP;
`else
          r_state <= IDLE;
          r_done  <= 1'b1;
`endif
        end
`ifdef NEC_REPEAT_EN
        GAP: begin
          if (!cmd_hold) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_cyc   <= '0;
            r_units <= '0;
          end else if (w_unit_end && r_period == 8'd191) begin
            // 192 units since the previous lead/repeat mark began
            r_state    <= RPT_MARK;
            r_mark     <= 1'b1;
            r_carr     <= 1'b1;
            r_carr_cnt <= '0;
            r_period   <= '0;
            r_units    <= '0;
          end
        end
        RPT_MARK: if (w_seg_end) begin
          r_state <= RPT_SPACE;
          r_mark  <= 1'b0;
          r_units <= '0;
        end
        RPT_SPACE: if (w_seg_end) begin
          r_state    <= RPT_STOP;
          r_mark     <= 1'b1;
          r_carr     <= 1'b1;
          r_carr_cnt <= '0;
          r_units    <= '0;
        end
        RPT_STOP: if (w_seg_end) begin
          r_state <= GAP;
          r_mark  <= 1'b0;
          r_units <= '0;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = ~cmd_ready;
  assign ir_mark   = r_mark;
  assign ir_out    = r_mark & r_carr;
  assign done      = r_done;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Randomised bench for nec_ir_tx against a frame-level envelope model (UNIT_CYC=4, CARR_HALF=1).
module tb_nec_ir_tx;
  localparam int UNIT = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_hold = 1'b0;
  logic       cmd_ready, ir_mark, ir_out, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[$];

  always #5 sys_clk = ~sys_clk;

  nec_ir_tx #(.ADDR(8'h00), .UNIT_CYC(UNIT), .CARR_HALF(1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_hold(cmd_hold), .ir_mark(ir_mark), .ir_out(ir_out),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frame_word(input logic [7:0] cmd);
    logic [7:0] addr;
    addr = 8'h00;
    return {~cmd, cmd, ~addr, addr};
  endfunction

  // Expected per-cycle envelope of one frame, starting the cycle after the handshake.
  function automatic void build_env(input logic [7:0] cmd);
    logic [31:0] f;
    f = frame_word(cmd);
    exp_q.delete();
    repeat (16 * UNIT) exp_q.push_back(1'b1);
    repeat (8 * UNIT) exp_q.push_back(1'b0);
    for (int b = 0; b < 32; b++) begin
      repeat (UNIT) exp_q.push_back(1'b1);
      repeat ((f[b] ? 3 : 1) * UNIT) exp_q.push_back(1'b0);
    end
    repeat (UNIT) exp_q.push_back(1'b1);
  endfunction

  task automatic run_frame(input logic [7:0] cmd, input bit keep_valid, output logic [31:0] dec);
    int merr = 0, oerr = 0, rerr = 0, k = 0, p, z;
    bit prev = 1'b0;
    bit obs[$];
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    build_env(cmd);
    @(posedge sys_clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge sys_clk);
      if (!keep_valid) cmd_valid = 1'b0;
      else cmd_data = 8'($urandom);
      obs.push_back(ir_mark);
      if (ir_mark !== exp_q[i]) merr++;
      k = (exp_q[i] && prev) ? k + 1 : 0;
      prev = exp_q[i];
      if (ir_out !== (exp_q[i] && (k % 2 == 0))) oerr++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) rerr++;
    end
    check("envelope_errs", merr, 0);
    check("carrier_errs", oerr, 0);
    check("busy_errs", rerr, 0);
    dec = '0;
    p = 24 * UNIT;
    for (int b = 0; b < 32; b++) begin
      p += UNIT;
      z = 0;
      while (p < obs.size() && obs[p] == 1'b0) begin
        z++;
        p++;
      end
      dec[b] = (z > 2 * UNIT);
    end
    check("decoded_bits", dec, frame_word(cmd));
    @(negedge sys_clk);
`ifdef NEC_REPEAT_EN
    check("gap_ready", cmd_ready, 0);
    @(negedge sys_clk);
`endif
    check("done_pulse", done, 1);
    check("ready_after", cmd_ready, 1);
  endtask

  initial begin
    logic [31:0] dec;
    logic [7:0]  c;
    logic [31:0] f;
    int errs, off;

    repeat (3) @(negedge sys_clk);
    check("rst_mark", ir_mark, 0);
    check("rst_out", ir_out, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    sys_rst_n = 1'b1;

    errs = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (ir_mark !== 1'b0 || ir_out !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) errs++;
    end
    check("idle_errs", errs, 0);

    run_frame(8'h46, 1'b0, dec);
    check("nec_46_word", dec, 32'hB946FF00);
    repeat (5) @(negedge sys_clk);

    // 8'h15 with valid held high, then 8'h44 immediately on the done cycle
    run_frame(8'h15, 1'b1, dec);
    run_frame(8'h44, 1'b0, dec);
    repeat (3) @(negedge sys_clk);

    // Reset partway into bit 10
    c = 8'($urandom);
    f = frame_word(c);
    off = 24 * UNIT;
    for (int b = 0; b < 10; b++) off += UNIT + (f[b] ? 3 : 1) * UNIT;
    off += 2;
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    repeat (off) @(negedge sys_clk);
    check("bit10_mark", ir_mark, 1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    check("abort_mark", ir_mark, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    run_frame(8'h43, 1'b0, dec);

    run_frame(8'h40, 1'b0, dec);

    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(1, 20)) @(negedge sys_clk);
      run_frame(8'($urandom), 1'b0, dec);
    end

`ifdef NEC_REPEAT_EN
    begin
      bit rq[$];
      int done_cnt = 0, done_idx = -1;
      build_env(8'($urandom));
      rq = exp_q;
      while (rq.size() < 2600) rq.push_back(1'b0);
      for (int r = 1; r <= 3; r++) begin
        for (int j = 0; j < 64; j++) rq[r * 192 * UNIT + j] = 1'b1;
        for (int j = 80; j < 84; j++) rq[r * 192 * UNIT + j] = 1'b1;
      end
      errs = 0;
      repeat (3) @(negedge sys_clk);
      cmd_hold  = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = 8'($urandom);
      build_env(cmd_data);
      for (int j = 0; j < exp_q.size(); j++) rq[j] = exp_q[j];
      @(posedge sys_clk);
      for (int i = 0; i < 2600; i++) begin
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        if (ir_mark !== rq[i]) errs++;
        if (done === 1'b1) begin
          done_cnt++;
          done_idx = i;
        end
        if (i == 2500) cmd_hold = 1'b0;
      end
      check("rpt_envelope_errs", errs, 0);
      check("rpt_done_count", done_cnt, 1);
      check("rpt_done_idx", done_idx, 2501);
      check("rpt_ready_after", cmd_ready, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
- NEC infrared transmitter; the transmit-side counterpart of the IR receive/decode path.
- Accepts one 8-bit command byte per valid/ready handshake.
- Serialises a full NEC frame: 9 ms lead, 4.5 ms space, 32 data bits, stop mark.
- Drives a baseband mark signal and a carrier-modulated output for an IR LED, so boards can drive the snake game remotely or self-test the receive path in loopback.

Parameters:
- ADDR, 8'h00, NEC device address sent in every frame.
- UNIT_CYC, 28125, clock cycles per NEC unit (562.5 µs at 50 MHz); must be ≥2.
- CARR_HALF, 658, clock cycles per carrier half-period (≈38 kHz at 50 MHz); must be ≥1.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  synchronous active-low reset.
- cmd_data  in  8  command byte, e.g. 8'h46 or 8'h15; sampled on handshake.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; transfer occurs when cmd_valid & cmd_ready.
- cmd_hold  in  1  key still pressed; used only when NEC_REPEAT_EN is defined, ignored otherwise.
- ir_mark  out  1  baseband envelope; 1 = mark (carrier on).
- ir_out  out  1  ir_mark AND carrier.
- busy  out  1  equals ~cmd_ready.
- done  out  1  one-cycle pulse when a frame or repeat sequence ends.

Behaviour:
- Clocking/reset:
  - Single clock; reset is synchronous and active-low.
  - While sys_rst_n=0 at a clock edge: state=IDLE, counters=0, ir_mark=0, ir_out=0, done=0, cmd_ready=1, busy=0.
  - Reset mid-frame aborts the frame immediately at that edge. Nothing resumes afterwards.
- Frame register:
  - On handshake, latch shift = {~cmd_data, cmd_data, ~ADDR, ADDR}.
  - Transmit LSB first: ADDR bit0 first, ~cmd bit7 last.
- States and durations (in units; 1 unit = UNIT_CYC cycles):
  - IDLE: no output; cmd_ready=1.
  - LEAD_MARK: 16 units, mark.
  - LEAD_SPACE: 8 units, space.
  - BIT_MARK: 1 unit, mark.
  - BIT_SPACE: 1 unit for a 0 bit, 3 units for a 1 bit.
  - STOP_MARK: 1 unit, mark.
  - Transitions: BIT_SPACE returns to BIT_MARK until 32 bits are done, then goes to STOP_MARK. STOP_MARK goes to IDLE, or to GAP when the repeat feature is enabled.
- Timing:
  - Handshake in cycle N gives LEAD_MARK from cycle N+1; ir_mark is registered and first reads 1 at N+1.
  - cmd_ready goes 0 from N+1.
  - Frame length = (89 + 2·popcount(frame)) units exactly. There are no idle cycles between segments.
  - done=1 in the first cycle back in IDLE. cmd_ready=1 in that same cycle.
  - A new handshake in that cycle starts the next frame at the following cycle.
- Handshake rules:
  - cmd_valid while busy is ignored and not queued.
  - cmd_data is sampled only on handshake; changes mid-frame have no effect.
- Carrier:
  - 1-bit carrier toggles every CARR_HALF cycles.
  - Its counter and phase reset at the start of every mark segment, so each burst starts with carrier=1.
  - ir_out=0 whenever ir_mark=0.
- Counters:
  - Unit cycle counter width ≥ clog2(UNIT_CYC); unit counter ≥5 bits.
  - Repeat-period counter: 8 bits, counts up to 192.
  - No wrap within a legal frame.

Optional Feature:
- Macro: NEC_REPEAT_EN.
- Defined:
  - After STOP_MARK, enter GAP instead of IDLE.
  - GAP ends 192 units after the start of the previous LEAD_MARK or RPT_MARK (108 ms period).
  - At the end of GAP: if cmd_hold=1, send a repeat code: RPT_MARK 16 units mark, RPT_SPACE 4 units space, RPT_STOP 1 unit mark, then GAP again.
  - If cmd_hold=0 at the end of GAP, go to IDLE with done=1.
  - If cmd_hold falls during GAP, go to IDLE immediately with done=1.
  - cmd_ready=0 throughout GAP and repeats.
- Not defined:
  - cmd_hold is ignored.
  - STOP_MARK goes directly to IDLE.
  - GAP and repeat states and the period counter are not synthesised.

Test Plan:
- Parameter setting for all tests: UNIT_CYC=4, CARR_HALF=1.
- Reset then idle → ir_mark=0, ir_out=0, cmd_ready=1, done=0 for 100 cycles.
- Handshake cmd_data=8'h46, ADDR=8'h00 → mark 64 cycles, space 32. Decoded bits LSB-first equal 32'hB946FF00. Frame lasts (89+2·16)·4=484 cycles. done pulses once; cmd_ready returns to 1.
- cmd_valid held high with 8'h15 during a frame, then 8'h44 → exactly one frame per handshake, back-to-back. The second lead mark starts the cycle after done. The mid-frame value is ignored.
- Assert sys_rst_n=0 during bit 10 → at the next edge ir_mark=0 and cmd_ready=1. A later handshake with 8'h43 sends a clean full frame.
- Carrier check on 8'h40 → ir_out toggles every cycle only while ir_mark=1. ir_out=1 on the first cycle of every mark segment.
- NEC_REPEAT_EN, cmd_hold=1 for 3 periods then 0 → after the frame, repeats start at 768, 1536, 2304 cycles from the first lead start. Each repeat is mark 64, space 16, mark 4 cycles. done pulses once, after the last repeat.
